ucie_clk_repair_pattern_gen: RTL

Parametrised, single-clock generator for the mainband clock-lane repair/training pattern (CKP, CKN, TRK and any extra clock lanes). It runs a configurable burst of N toggle cycles followed by M quiet cycles, repeated ITERATIONS times. Lanes run either all at once or walked one by one, with per-lane detector enables and a done/busy handshake to the MB training FSM. Outside repair it produces a registered clock-gate enable for strobe/continuous forwarding.

---
 rtl/ucie_clk_repair_pattern_gen.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ucie_clk_repair_pattern_gen.sv
// ucie_clk_repair_pattern_gen
// Drives the mainband clock-lane repair pattern (CKP/CKN/TRK and extra
// clock lanes). A burst is TOGGLE_CYCLES alternating cycles followed by
// IDLE_CYCLES low cycles, repeated ITERATIONS times per lane. Lanes run
// together or are walked one at a time. Outside repair the block produces
// the forwarding clock-gate enable.
//
// Handshake with the training FSM: i_repair_en is a level. Raising it starts
// a run, which reports o_busy while patterns are driven and then raises the
// sticky o_done. Holding i_repair_en high keeps the block parked in DONE.
// Dropping it at any point returns everything to IDLE on the next edge.
//
// o_dbg_state exposes the FSM: 0=IDLE 1=TOGGLE 2=QUIET 3=NEXT 4=DONE.
module ucie_clk_repair_pattern_gen #(
    parameter int NUM_LANES     = 3,
    parameter int TOGGLE_CYCLES = 32,
    parameter int IDLE_CYCLES   = 16,
    parameter int ITERATIONS    = 614,
    parameter logic [NUM_LANES-1:0] DIFF_MASK = NUM_LANES'(3'b010),
    localparam int LIDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_repair_en,
    input  logic                 i_seq_mode,
    input  logic [NUM_LANES-1:0] i_lane_mask,
    input  logic                 i_mode,
    input  logic                 i_valid,
    output logic [NUM_LANES-1:0] o_pattern,
    output logic [NUM_LANES-1:0] o_det_en,
    output logic [LIDX_W-1:0]    o_lane_idx,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_clk_en,
    output logic [2:0]           o_dbg_state
);

    localparam int CNT_MAX = (TOGGLE_CYCLES > IDLE_CYCLES) ? TOGGLE_CYCLES : IDLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int ITER_W  = $clog2(ITERATIONS + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_TOGGLE = 3'd1;
    localparam logic [2:0] ST_QUIET  = 3'd2;
    localparam logic [2:0] ST_NEXT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ITER_W-1:0]    iter_q;
    logic [ITER_W-1:0]    iter_nxt;
    logic [NUM_LANES-1:0] mask_q;
    logic                 seq_q;

    logic [LIDX_W-1:0]    first_idx;
    logic [NUM_LANES-1:0] start_act;
    logic                 nxt_found;
    logic [LIDX_W-1:0]    nxt_idx;

    function automatic logic [NUM_LANES-1:0] lane_bit(input logic [LIDX_W-1:0] idx);
        return NUM_LANES'(1) << idx;
    endfunction

    assign o_dbg_state = state_q;
    assign iter_nxt    = iter_q + ITER_W'(1);

    // Lowest requested lane and the set of lanes driven on the start edge.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (i_lane_mask[i]) first_idx = LIDX_W'(i);
        end
        start_act = i_seq_mode ? lane_bit(first_idx) : i_lane_mask;
    end

    // Next latched mask lane strictly above the current lane pointer.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(o_lane_idx))) begin
                nxt_found = 1'b1;
                nxt_idx   = LIDX_W'(i);
            end
        end
    end

    // Repair FSM, burst/iteration counters and all registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            iter_q     <= '0;
            mask_q     <= '0;
            seq_q      <= 1'b0;
            o_pattern  <= '0;
            o_det_en   <= '0;
            o_lane_idx <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_clk_en   <= 1'b0;
        end else if (!i_repair_en) begin
            // Idle forwarding, or abort/clear of whatever run was in flight.
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            iter_q     <= '0;
            o_pattern  <= '0;
            o_det_en   <= '0;
            o_lane_idx <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_clk_en   <= (state_q == ST_IDLE) ? (i_mode | i_valid) : 1'b0;
        end else begin
            o_clk_en <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    mask_q <= i_lane_mask;
                    seq_q  <= i_seq_mode;
                    cnt_q  <= '0;
                    iter_q <= '0;
                    if (i_lane_mask == '0) begin
                        state_q    <= ST_DONE;
                        o_done     <= 1'b1;
                        o_busy     <= 1'b0;
                        o_det_en   <= '0;
                        o_pattern  <= '0;
                        o_lane_idx <= '0;
                    end else begin
                        state_q    <= ST_TOGGLE;
                        o_busy     <= 1'b1;
                        o_det_en   <= start_act;
                        o_pattern  <= start_act & ~DIFF_MASK;
                        o_lane_idx <= i_seq_mode ? first_idx : '0;
                    end
                end
                ST_TOGGLE: begin
                    // det_en holds exactly the active lanes, so it doubles as the toggle mask.
                    if (cnt_q == CNT_W'(TOGGLE_CYCLES - 1)) begin
                        cnt_q     <= '0;
                        o_pattern <= '0;
                        state_q   <= ST_QUIET;
                    end else begin
                        cnt_q     <= cnt_q + CNT_W'(1);
                        o_pattern <= o_pattern ^ o_det_en;
                    end
                end
                ST_QUIET: begin
                    if (cnt_q == CNT_W'(IDLE_CYCLES - 1)) begin
                        cnt_q  <= '0;
                        iter_q <= iter_nxt;
                        if (iter_nxt < ITER_W'(ITERATIONS)) begin
                            state_q   <= ST_TOGGLE;
                            o_pattern <= o_det_en & ~DIFF_MASK;
                        end else if (seq_q && nxt_found) begin
                            state_q  <= ST_NEXT;
                            o_det_en <= '0;
                        end else begin
                            state_q <= ST_DONE;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_NEXT: begin
                    state_q    <= ST_TOGGLE;
                    iter_q     <= '0;
                    o_lane_idx <= nxt_idx;
                    o_det_en   <= lane_bit(nxt_idx);
                    o_pattern  <= lane_bit(nxt_idx) & ~DIFF_MASK;
                end
                ST_DONE: begin
                    // Parked until i_repair_en drops; det_en and lane_idx keep their last values.
                    o_pattern <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
